wb_periph_xbar: RTL
===================

# wb_periph_xbar

Parametrised Wishbone peripheral interconnect for the user project area, generalising the fixed six-window decoder into an N-slave registered bridge. It decodes a contiguous window map and forwards single transactions to one of `NUM_SLV` peripherals with registered handshakes. It adds a bus-timeout watchdog, unmapped-address error response, error capture registers and a programmable interrupt router onto the 3 user IRQ lines. It sits between the user-area Wishbone slave port and the peripheral instances (SPI, I2C/I3C, GPIO, ...).

## Interface
Parameters:
- `NUM_SLV`, 6: number of peripheral windows, 1..15.
- `WIN_AW`, 10: log2 window size in bytes (1 KB).
- `BASE_ADDR`, 32'h3000_0000: start of window 0; must be aligned to 2^(WIN_AW+4).
- `TIMEOUT_CYC`, 255: WAIT cycles before timeout, 2..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on any error response.

Ports (one clock; reset is asynchronous and active-high):
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous active-high reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: master request.
- `wbs_sel_i` in 4, `wbs_adr_i` in 32, `wbs_dat_i` in 32: master byte enables, address, write data.
- `wbs_ack_o` out 1, `wbs_dat_o` out 32: registered master response.
- `s_cyc_o` out NUM_SLV: per-slave cyc, one-hot, also used as stb.
- `s_we_o` out 1, `s_sel_o` out 4, `s_adr_o` out 32, `s_dat_o` out 32: registered, shared by all slaves.
- `s_dat_i` in 32*NUM_SLV: slave read data; slave k in bits [32k+31:32k].
- `s_ack_i` in NUM_SLV: slave acks.
- `s_irq_i` in NUM_SLV: level interrupts from slaves.
- `irq_o` out 3: routed user IRQs.

## Operation
- Window k = `BASE_ADDR + k*2^WIN_AW`, for k < NUM_SLV. Window NUM_SLV is the CSR block. Anything else is unmapped.
- FSM states and transitions:
  - IDLE: on `cyc&stb`, latch adr/dat/sel/we, then:
    - slave window → WAIT;
    - CSR window → RESP, performing the access;
    - unmapped → RESP with ERR_DATA, setting `ERR.UNMAP`.
  - WAIT: `s_cyc_o[k]`=1.
    - `s_ack_i[k]` → RESP, capturing `s_dat_i[k]`.
    - Timeout → RESP with ERR_DATA, setting `ERR.TMO`, `ERR.IDX`=k and `ERR_ADDR`.
    - `wbs_cyc_i`=0 (abort) → IDLE, with no master ack and no error.
  - RESP: `wbs_ack_o`=1 for exactly one cycle → IDLE.
- CSR map (byte offset in CSR window; unlisted offsets read 0 and ignore writes):
  - 0x00 IRQ_MASK, RW, reset 0: bit s enables source s.
  - 0x04 IRQ_ROUTE, RW, reset all ones: 2 bits per source; value r<3 routes the source to `irq_o[r]`, value 3 disables it.
  - 0x08 IRQ_RAW, RO: `s_irq_i`.
  - 0x0C ERR, reset 0:
    - bit0 TMO and bit1 UNMAP are sticky W1C;
    - bits[11:8] IDX, RO.
  - 0x10 ERR_ADDR, RO, reset 0: address of the last error.
- `irq_o[r]` = registered OR over s of `s_irq_i[s] & IRQ_MASK[s] & (ROUTE[s]==r)`.
- `wbs_sel_i` applies to CSR writes per byte.
- Reset values: all outputs 0 except registers as listed above.

## Timing
- Request sampled in IDLE at cycle 0. Slave `s_cyc_o` is high from cycle 1.
- Slave ack at cycle n → `s_cyc_o` low and `wbs_ack_o` high at n+1 → IDLE at n+2. A zero-wait slave gives master ack at cycle 2.
- CSR access and unmapped address: master ack at cycle 1.
- Timeout counter:
  - cleared on WAIT entry, increments each WAIT cycle without ack;
  - expiry gives master ack at cycle 1+TIMEOUT_CYC;
  - an ack in the expiry cycle wins, with no error.
- One dead cycle between transactions; a held `stb` is re-sampled in IDLE as a new request.
- Simultaneous W1C and new error on the same bit: the set wins.
- `irq_o` lags `s_irq_i` or CSR changes by 1 cycle.
- Reset mid-transaction: FSM to IDLE and all outputs low immediately, asynchronously. Any slave ack after release is ignored.

## Configuration
- `WB_XBAR_TIMEOUT_EN`:
  - Defined: watchdog as above.
  - Undefined: no counter; WAIT ends only on ack or abort. `ERR.TMO` and `ERR.IDX` read 0, and `ERR_ADDR` updates only on UNMAP.

## Test plan
- Write 0x1234_5678 to 0x3000_0404, slave 1 acks at cycle 3 → `s_cyc_o`=6'b000010 in cycles 1–3, `s_dat_o`=0x1234_5678, `wbs_ack_o` at cycle 4 only.
- Read 0x3000_0C00, slave 3 returns 0xA5A5_0003 → `wbs_dat_o`=0xA5A5_0003 with `wbs_ack_o`; other slave data is ignored.
- Read 0x3000_0800, slave 2 never acks, TIMEOUT_CYC=255 → ack at cycle 256, data 0xDEAD_BEEF. ERR reads 0x201 and ERR_ADDR reads 0x3000_0800. Writing 0x1 to ERR clears it to 0x200.
- Read 0x3000_4000 (unmapped) → ack at cycle 1, data 0xDEAD_BEEF, `ERR.UNMAP`=1, no `s_cyc_o` activity.
- IRQ_MASK=0x21, IRQ_ROUTE=0xFFFF_F7FE (src0→line2, src5→line1), drive `s_irq_i`=6'b100001 → `irq_o`=3'b110 one cycle later. With mask 0 → `irq_o`=0.
- Assert `wb_rst_i` in WAIT → `s_cyc_o` and `wbs_ack_o` go 0 immediately. After release, a late `s_ack_i` gives no master ack.

Source files
------------

// File: rtl/wb_periph_xbar.sv
// wb_periph_xbar: registered Wishbone bridge fanning one user-area slave port
// out to NUM_SLV peripheral windows, plus a CSR window (window NUM_SLV) with
// an IRQ router and error capture.
// Optional feature macro: WB_XBAR_TIMEOUT_EN enables the bus-timeout watchdog.
// Handshake: a master request is taken when wbs_cyc_i & wbs_stb_i are high
// in IDLE; the bridge answers with a single-cycle wbs_ack_o. Toward a slave,
// s_cyc_o[k] doubles as strobe and stays high until s_ack_i[k], timeout or
// master abort (wbs_cyc_i low).
module wb_periph_xbar #(
  parameter int          NUM_SLV     = 6,
  parameter int          WIN_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_SLV-1:0]      s_cyc_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [32*NUM_SLV-1:0]   s_dat_i,
  input  logic [NUM_SLV-1:0]      s_ack_i,
  input  logic [NUM_SLV-1:0]      s_irq_i,
  output logic [2:0]              irq_o
);

  localparam int         OW      = WIN_AW - 2;  // CSR word-offset width
  localparam int         TW      = WIN_AW + 4;  // 16-window block boundary
  localparam logic [3:0] CSR_IDX = 4'(NUM_SLV);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         slv_q, slv_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic [NUM_SLV-1:0] cyc_q, cyc_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdat_q, rdat_d;
  logic [NUM_SLV-1:0] mask_q, mask_d;
  logic [31:0]        route_q, route_d;
  logic               tmo_q, tmo_d;
  logic               unmap_q, unmap_d;
  logic [3:0]         idx_q, idx_d;
  logic [31:0]        eaddr_q, eaddr_d;
  logic [2:0]         irq_q, irq_d;
`ifdef WB_XBAR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0]        cnt_q, cnt_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Address decode: windows live in one aligned 16-window block.
  logic          hit_base;
  logic [3:0]    win_idx;
  logic [OW-1:0] csr_word;
  logic          is_slv;
  logic          is_csr;
  logic          unused_adr_lsb;

  assign hit_base       = (wbs_adr_i[31:TW] == BASE_ADDR[31:TW]);
  assign win_idx        = wbs_adr_i[TW-1:WIN_AW];
  assign csr_word       = wbs_adr_i[WIN_AW-1:2];
  assign is_slv         = hit_base && (win_idx < CSR_IDX);
  assign is_csr         = hit_base && (win_idx == CSR_IDX);
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // CSR read mux, addressed by the incoming request.
  logic [31:0] csr_rdata;
  always_comb begin
    csr_rdata = '0;
    case (csr_word)
      OW'(0):  csr_rdata = 32'(mask_q);
      OW'(1):  csr_rdata = route_q;
      OW'(2):  csr_rdata = 32'(s_irq_i);
      OW'(3):  csr_rdata = {20'd0, idx_q, 6'd0, unmap_q, tmo_q};
      OW'(4):  csr_rdata = eaddr_q;
      default: csr_rdata = '0;
    endcase
  end

  // Select data and ack of the slave currently being accessed.
  logic [31:0] slv_rdata;
  logic        slv_ack;
  always_comb begin
    slv_rdata = '0;
    slv_ack   = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (slv_q == 4'(k)) begin
        slv_rdata = s_dat_i[32*k +: 32];
        slv_ack   = s_ack_i[k];
      end
    end
  end

  // Interrupt router: each enabled source feeds the line its route field names.
  always_comb begin
    irq_d = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      for (int r = 0; r < 3; r++) begin
        if (s_irq_i[s] && mask_q[s] && (route_q[2*s +: 2] == 2'(r))) begin
          irq_d[r] = 1'b1;
        end
      end
    end
  end

  // Bridge FSM next state, CSR writes and error capture.
  always_comb begin
    state_d = state_q;
    slv_d   = slv_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    mask_d  = mask_q;
    route_d = route_q;
    tmo_d   = tmo_q;
    unmap_d = unmap_q;
    idx_d   = idx_q;
    eaddr_d = eaddr_q;
`ifdef WB_XBAR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          sel_d  = wbs_sel_i;
          we_d   = wbs_we_i;
          if (is_slv) begin
            slv_d   = win_idx;
            cyc_d   = NUM_SLV'(1) << win_idx;
            state_d = ST_WAIT;
`ifdef WB_XBAR_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else if (is_csr) begin
            ack_d   = 1'b1;
            state_d = ST_RESP;
            rdat_d  = wbs_we_i ? 32'd0 : csr_rdata;
            if (wbs_we_i) begin
              case (csr_word)
                OW'(0): begin
                  for (int s = 0; s < NUM_SLV; s++) begin
                    if (wbs_sel_i[s/8]) mask_d[s] = wbs_dat_i[s];
                  end
                end
                OW'(1): route_d = byte_merge(route_q, wbs_dat_i, wbs_sel_i);
                OW'(3): begin
                  if (wbs_sel_i[0] && wbs_dat_i[0]) tmo_d   = 1'b0;
                  if (wbs_sel_i[0] && wbs_dat_i[1]) unmap_d = 1'b0;
                end
                default: ;
              endcase
            end
          end else begin
            ack_d   = 1'b1;
            rdat_d  = ERR_DATA;
            unmap_d = 1'b1;
            eaddr_d = wbs_adr_i;
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
        end else if (slv_ack) begin
          cyc_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = slv_rdata;
          state_d = ST_RESP;
        end
`ifdef WB_XBAR_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          cyc_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = ERR_DATA;
          tmo_d   = 1'b1;
          idx_d   = slv_q;
          eaddr_d = adr_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered outputs and CSRs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      slv_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= '0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      mask_q  <= '0;
      route_q <= '1;
      tmo_q   <= 1'b0;
      unmap_q <= 1'b0;
      idx_q   <= '0;
      eaddr_q <= '0;
      irq_q   <= '0;
`ifdef WB_XBAR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slv_q   <= slv_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      mask_q  <= mask_d;
      route_q <= route_d;
      tmo_q   <= tmo_d;
      unmap_q <= unmap_d;
      idx_q   <= idx_d;
      eaddr_q <= eaddr_d;
      irq_q   <= irq_d;
`ifdef WB_XBAR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign s_cyc_o   = cyc_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = wdat_q;
  assign irq_o     = irq_q;

endmodule
